// File: rtl/keypad_pkg.sv
// Shared types and helpers for the keypad BCD entry block.
package keypad_pkg;

  localparam int unsigned BCD_W    = 4;
  localparam int unsigned MAX_KEYS = 10;

  typedef enum logic [1:0] {IDLE, DEBOUNCE, HELD} state_t;

  function automatic logic [BCD_W-1:0] onehot_to_bcd(input logic [MAX_KEYS-1:0] oh);
    logic [BCD_W-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < MAX_KEYS; i++) begin
      if (oh[i]) r = BCD_W'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/keypad_bcd_entry_debounce.sv
// Key synchroniser, debounce FSM and press detector: one acc pulse per debounced press.
// Optional sticky multi-key error when KEYPAD_MULTI_ERR_EN is defined.
module key_debounce
  import keypad_pkg::*;
#(
  parameter int unsigned NUM_KEYS     = 10,
  parameter int unsigned DEBOUNCE_CYC = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                clear,
  input  logic [NUM_KEYS-1:0] keys,
  output logic                acc,
  output logic [BCD_W-1:0]    code,
  output logic                err
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYC + 1);

  state_t              state;
  logic [NUM_KEYS-1:0] s1, ks, key_l;
  logic [CW-1:0]       cnt;
  logic                zero, onehot;

  always_comb begin
    zero   = (ks == '0);
    onehot = !zero && ((ks & (ks - NUM_KEYS'(1))) == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1    <= '0;
      ks    <= '0;
      key_l <= '0;
      cnt   <= '0;
      acc   <= 1'b0;
      code  <= '0;
      state <= IDLE;
    end else begin
      s1  <= keys;
      ks  <= s1;
      acc <= 1'b0;
      if (!en) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (onehot) begin
              key_l <= ks;
              cnt   <= CW'(1);
              state <= DEBOUNCE;
            end
          end
          DEBOUNCE: begin
            if (ks != key_l) begin
              state <= IDLE;
            end else if (cnt == CW'(DEBOUNCE_CYC)) begin
              acc   <= 1'b1;
              code  <= onehot_to_bcd(MAX_KEYS'(key_l));
              cnt   <= '0;
              state <= HELD;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          HELD: begin
            // cnt counts consecutive released samples; any key activity restarts it
            if (!zero) begin
              cnt <= '0;
            end else if (cnt == CW'(DEBOUNCE_CYC - 1)) begin
              state <= IDLE;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

`ifdef KEYPAD_MULTI_ERR_EN
  logic multi;
  assign multi = !zero && !onehot;

  // A multi-hot ks already sends DEBOUNCE back to IDLE via the key_l mismatch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else if (clear) begin
      err <= 1'b0;
    end else if (en && multi && (state != HELD)) begin
      err <= 1'b1;
    end
  end
`else
  logic unused_clear;
  assign unused_clear = clear;
  assign err          = 1'b0;
`endif

endmodule

// File: rtl/keypad_bcd_entry.sv
// Debounced one-hot keypad to BCD entry register (newest digit in digits[3:0]).
// Define KEYPAD_MULTI_ERR_EN to enable the sticky multi-key error flag.
module keypad_bcd_entry
  import keypad_pkg::*;
#(
  parameter int unsigned NUM_KEYS     = 10,
  parameter int unsigned DEBOUNCE_CYC = 4,
  parameter int unsigned DIGITS       = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         en,
  input  logic                         clear,
  input  logic [NUM_KEYS-1:0]          keys,
  output logic [3:0]                   bcd,
  output logic                         loadn,
  output logic [4*DIGITS-1:0]          digits,
  output logic [$clog2(DIGITS+1)-1:0]  count,
  output logic                         full,
  output logic                         err
);

  localparam int unsigned CNT_W = $clog2(DIGITS + 1);
  localparam int unsigned DW    = BCD_W * DIGITS;

  logic             acc;
  logic [BCD_W-1:0] code;

  key_debounce #(
    .NUM_KEYS     (NUM_KEYS),
    .DEBOUNCE_CYC (DEBOUNCE_CYC)
  ) u_deb (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .clear (clear),
    .keys  (keys),
    .acc   (acc),
    .code  (code),
    .err   (err)
  );

  assign bcd   = code;
  assign loadn = ~acc;

  // The digit is taken while loadn is low, so a clear in that cycle drops it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digits <= '0;
      count  <= '0;
      full   <= 1'b0;
    end else if (clear) begin
      digits <= '0;
      count  <= '0;
      full   <= 1'b0;
    end else if (acc && !full) begin
      digits <= (digits << BCD_W) | DW'(code);
      count  <= count + CNT_W'(1);
      full   <= (count == CNT_W'(DIGITS - 1));
    end
  end

endmodule
